// File: rtl/regfile_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE,
        RF_SWEEP
    } rf_state_e;

    localparam int RF_DATA_W = 8;
    localparam int RF_ADDR_W = 3;

    // One bit of the one-hot decode of an address (addresses up to 16 bits).
    function automatic logic rf_dec(input logic [15:0] addr,
                                    input int unsigned idx);
        return addr == 16'(idx);
    endfunction

endpackage

// File: rtl/register_file_sb_scoreboard.sv
// Per-register busy bits: set by MARK, cleared by write or by sweep index.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              sweep_en,
    input  logic [ADDR_W-1:0] sweep_addr,
    input  logic [ADDR_W-1:0] rd_a_addr,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic              busy_a,
    output logic              busy_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Set has priority over clear so MARK wins over a same-cycle write.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sweep_en && rf_dec(16'(sweep_addr), i))
                busy_d[i] = 1'b0;
            else if (set_en && rf_dec(16'(set_addr), i))
                busy_d[i] = 1'b1;
            else if (clr_en && rf_dec(16'(clr_addr), i))
                busy_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign busy_a = busy_q[rd_a_addr];
    assign busy_b = busy_q[rd_b_addr];

endmodule

// File: rtl/register_file_sb.sv
// Parametrised 2R/1W register file with busy scoreboard and clear sweep.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] SA,
    input  logic [ADDR_W-1:0] SB,
    input  logic [ADDR_W-1:0] DR,
    input  logic              LD,
    input  logic [DATA_W-1:0] D_in,
    input  logic              MARK,
    input  logic [ADDR_W-1:0] MARK_DR,
    input  logic              CLR_REQ,
    output logic [DATA_W-1:0] DATA_A,
    output logic [DATA_W-1:0] DATA_B,
    output logic              RDY_A,
    output logic              RDY_B,
    output logic              CLR_BUSY,
    output logic              LD_ERR
);

    localparam int DEPTH = 1 << ADDR_W;

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              sweeping;
    logic              wr_ok, mk_ok;
    logic              zero_a, zero_b;
    logic              byp_a, byp_b;
    logic              busy_a, busy_b;
    logic              ld_err_q;

    assign sweeping = (state_q == RF_SWEEP);
    assign zero_a   = (ZERO_REG != 0) && (SA == '0);
    assign zero_b   = (ZERO_REG != 0) && (SB == '0);
    assign wr_ok    = LD && !sweeping
                      && !((ZERO_REG != 0) && (DR == '0));
    assign mk_ok    = MARK && !sweeping
                      && !((ZERO_REG != 0) && (MARK_DR == '0));
    assign byp_a    = (BYPASS != 0) && wr_ok && (DR == SA);
    assign byp_b    = (BYPASS != 0) && wr_ok && (DR == SB);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            RF_IDLE: begin
                if (CLR_REQ) begin
                    state_d = RF_SWEEP;
                    idx_d   = '0;
                end
            end
            RF_SWEEP: begin
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RF_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = RF_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= RF_IDLE;
            idx_q    <= '0;
            ld_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ld_err_q <= sweeping && (LD || MARK);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
        end else if (sweeping) begin
            regs_q[idx_q] <= '0;
        end else if (wr_ok) begin
            regs_q[DR] <= D_in;
        end
    end

    rf_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_sb (
        .clk       (CLK),
        .rst       (RESET),
        .set_en    (mk_ok),
        .set_addr  (MARK_DR),
        .clr_en    (wr_ok),
        .clr_addr  (DR),
        .sweep_en  (sweeping),
        .sweep_addr(idx_q),
        .rd_a_addr (SA),
        .rd_b_addr (SB),
        .busy_a    (busy_a),
        .busy_b    (busy_b)
    );

    always_comb begin
        if (zero_a)
            DATA_A = '0;
        else if (byp_a)
            DATA_A = D_in;
        else
            DATA_A = regs_q[SA];

        if (zero_b)
            DATA_B = '0;
        else if (byp_b)
            DATA_B = D_in;
        else
            DATA_B = regs_q[SB];
    end

    // A sweep hides every operand, including the hardwired zero.
    always_comb begin
        if (sweeping)
            RDY_A = 1'b0;
        else if (zero_a)
            RDY_A = 1'b1;
        else if (byp_a)
            RDY_A = !(mk_ok && (MARK_DR == SA));
        else
            RDY_A = !busy_a;

        if (sweeping)
            RDY_B = 1'b0;
        else if (zero_b)
            RDY_B = 1'b1;
        else if (byp_b)
            RDY_B = !(mk_ok && (MARK_DR == SB));
        else
            RDY_B = !busy_b;
    end

    assign CLR_BUSY = sweeping;
    assign LD_ERR   = ld_err_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: three parameter variants, shared stimulus.
module tb_register_file_sb;

    localparam int S_DA  = 0;
    localparam int S_DB  = 1;
    localparam int S_RA  = 2;
    localparam int S_RB  = 3;
    localparam int S_CB  = 4;
    localparam int S_LE  = 5;
    localparam int S_NDA = 6;
    localparam int S_ZDA = 7;
    localparam int S_ZRA = 8;
    localparam int S_ZLE = 9;

    typedef struct {
        string      name;
        int         sig;
        logic [7:0] exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sa, sb, dr, mark_dr;
    logic       ld, mark, clr_req;
    logic [7:0] d_in;

    logic [7:0] da, db, n_da, n_db, z_da, z_db;
    logic       ra, rb, cb, le;
    logic       n_ra, n_rb, n_cb, n_le;
    logic       z_ra, z_rb, z_cb, z_le;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    register_file_sb #(
        .DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)
    ) u_main (
        .CLK(clk), .RESET(rst), .SA(sa), .SB(sb), .DR(dr), .LD(ld),
        .D_in(d_in), .MARK(mark), .MARK_DR(mark_dr), .CLR_REQ(clr_req),
        .DATA_A(da), .DATA_B(db), .RDY_A(ra), .RDY_B(rb),
        .CLR_BUSY(cb), .LD_ERR(le)
    );

    register_file_sb #(
        .DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)
    ) u_nb (
        .CLK(clk), .RESET(rst), .SA(sa), .SB(sb), .DR(dr), .LD(ld),
        .D_in(d_in), .MARK(mark), .MARK_DR(mark_dr), .CLR_REQ(clr_req),
        .DATA_A(n_da), .DATA_B(n_db), .RDY_A(n_ra), .RDY_B(n_rb),
        .CLR_BUSY(n_cb), .LD_ERR(n_le)
    );

    register_file_sb #(
        .DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)
    ) u_z (
        .CLK(clk), .RESET(rst), .SA(sa), .SB(sb), .DR(dr), .LD(ld),
        .D_in(d_in), .MARK(mark), .MARK_DR(mark_dr), .CLR_REQ(clr_req),
        .DATA_A(z_da), .DATA_B(z_db), .RDY_A(z_ra), .RDY_B(z_rb),
        .CLR_BUSY(z_cb), .LD_ERR(z_le)
    );

    function automatic logic [7:0] actual(input int s);
        case (s)
            S_DA:    return da;
            S_DB:    return db;
            S_RA:    return {7'd0, ra};
            S_RB:    return {7'd0, rb};
            S_CB:    return {7'd0, cb};
            S_LE:    return {7'd0, le};
            S_NDA:   return n_da;
            S_ZDA:   return z_da;
            S_ZRA:   return {7'd0, z_ra};
            S_ZLE:   return {7'd0, z_le};
            default: return 8'hxx;
        endcase
    endfunction

    task automatic chk(input string name, input int sig, input logic [7:0] v);
        q.push_back('{name, sig, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ld      = 1'b0;
        mark    = 1'b0;
        clr_req = 1'b0;
    endtask

    // Monitor: outputs are combinational, so sample on the falling edge.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [7:0] act;
        while (q.size() > 0) begin
            e   = q.pop_front();
            act = actual(e.sig);
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1;
        sa = '0; sb = '0; dr = '0; mark_dr = '0; d_in = '0;
        idle();

        // Reset state
        step();
        chk("rst_da", S_DA, 8'h00);
        chk("rst_db", S_DB, 8'h00);
        chk("rst_ra", S_RA, 8'h01);
        chk("rst_rb", S_RB, 8'h01);
        chk("rst_cb", S_CB, 8'h00);
        chk("rst_le", S_LE, 8'h00);

        // Write/read
        step();
        rst = 1'b0;
        ld = 1'b1; dr = 3'd5; d_in = 8'hA5; sa = 3'd1; sb = 3'd0;
        step();
        idle();
        sa = 3'd5; sb = 3'd0;
        chk("wr_da", S_DA, 8'hA5);
        chk("wr_db", S_DB, 8'h00);
        chk("wr_ra", S_RA, 8'h01);
        chk("wr_rb", S_RB, 8'h01);
        chk("wr_zda", S_ZDA, 8'hA5);

        // Bypass vs no bypass
        step();
        ld = 1'b1; dr = 3'd3; d_in = 8'h3C; sa = 3'd3;
        chk("byp_da", S_DA, 8'h3C);
        chk("nobyp_da", S_NDA, 8'h00);
        chk("byp_zda", S_ZDA, 8'h3C);
        step();
        idle();
        chk("nobyp_after", S_NDA, 8'h3C);

        // Scoreboard
        step();
        mark = 1'b1; mark_dr = 3'd2; sa = 3'd2;
        chk("mark_pre_ra", S_RA, 8'h01);
        step();
        idle();
        chk("mark_ra", S_RA, 8'h00);
        step();
        ld = 1'b1; dr = 3'd2; d_in = 8'h11;
        chk("ld_byp_ra", S_RA, 8'h01);
        chk("ld_byp_da", S_DA, 8'h11);
        step();
        idle();
        chk("ld_post_ra", S_RA, 8'h01);
        chk("ld_post_da", S_DA, 8'h11);
        step();
        mark = 1'b1; mark_dr = 3'd2; ld = 1'b1; dr = 3'd2; d_in = 8'h11;
        chk("mkld_same_ra", S_RA, 8'h00);
        step();
        idle();
        chk("mkld_post_ra", S_RA, 8'h00);
        chk("mkld_post_da", S_DA, 8'h11);

        // Hardwired zero register
        step();
        ld = 1'b1; dr = 3'd0; d_in = 8'hFF; sa = 3'd0;
        chk("z_wr_zda", S_ZDA, 8'h00);
        chk("z_wr_da", S_DA, 8'hFF);
        step();
        idle();
        chk("z_post_zda", S_ZDA, 8'h00);
        chk("z_post_zle", S_ZLE, 8'h00);
        chk("z_post_da", S_DA, 8'hFF);
        step();
        mark = 1'b1; mark_dr = 3'd0;
        step();
        idle();
        chk("z_mark_zra", S_ZRA, 8'h01);
        chk("z_mark_ra", S_RA, 8'h00);

        // Fill, then sweep
        for (int k = 0; k < 8; k++) begin
            step();
            ld = 1'b1; dr = 3'(k); d_in = 8'(8'h10 + k);
        end
        step();
        idle();
        clr_req = 1'b1; sa = 3'd7; sb = 3'd0;
        chk("sw_pre_cb", S_CB, 8'h00);
        chk("sw_pre_da", S_DA, 8'h17);
        chk("sw_pre_db", S_DB, 8'h10);
        for (int c = 0; c <= 8; c++) begin
            step();
            clr_req = (c == 5);
            ld      = (c == 3);
            dr      = 3'd6;
            d_in    = 8'hEE;
            sa      = (c == 0) ? 3'd0 : 3'(c - 1);
            sb      = (c < 8) ? 3'(c) : 3'd7;
            chk($sformatf("sw%0d_cb", c), S_CB, (c < 8) ? 8'h01 : 8'h00);
            chk($sformatf("sw%0d_le", c), S_LE, (c == 4) ? 8'h01 : 8'h00);
            chk($sformatf("sw%0d_ra", c), S_RA, (c < 8) ? 8'h00 : 8'h01);
            chk($sformatf("sw%0d_da", c), S_DA, (c == 0) ? 8'h10 : 8'h00);
            chk($sformatf("sw%0d_db", c), S_DB,
                (c < 8) ? 8'(8'h10 + c) : 8'h00);
        end

        // Reset in the middle of a sweep
        step();
        idle();
        ld = 1'b1; dr = 3'd7; d_in = 8'h77;
        step();
        idle();
        clr_req = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            step();
            clr_req = 1'b0;
            sa = 3'd7;
            if (c < 3) begin
                chk($sformatf("mr%0d_cb", c), S_CB, 8'h01);
                chk($sformatf("mr%0d_da", c), S_DA, 8'h77);
            end
        end
        #2;
        rst = 1'b1;
        chk("mr_rst_cb", S_CB, 8'h00);
        chk("mr_rst_da", S_DA, 8'h00);
        chk("mr_rst_le", S_LE, 8'h00);
        step();
        rst = 1'b0;
        sa = 3'd7; sb = 3'd6;
        chk("mr_rel_da", S_DA, 8'h00);
        chk("mr_rel_db", S_DB, 8'h00);
        chk("mr_rel_cb", S_CB, 8'h00);
        step();
        clr_req = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            step();
            clr_req = 1'b0;
            chk($sformatf("rs%0d_cb", c), S_CB, (c < 8) ? 8'h01 : 8'h00);
        end

        step();
        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the 8x8 two-read/one-write register file.
- Generalised data width and depth. Optional hardwired-zero register 0. Optional write-to-read bypass.
- Per-register busy scoreboard, so the control unit can stall on in-flight results.
- Multi-cycle clear sequencer that zeroes the whole file without a global RESET.
- Sits between the control unit/ALU writeback and the datapath operand buses.

Parameters:
- DATA_W, 8: register width in bits.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 0: when 1, register 0 always reads 0, and writes/marks to it are discarded.
- BYPASS, 1: when 1, an accepted same-cycle write to a read address is forwarded to that read port.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SA  in  ADDR_W  read address, port A.
- SB  in  ADDR_W  read address, port B.
- DR  in  ADDR_W  write destination.
- LD  in  1  write enable.
- D_in  in  DATA_W  write data.
- MARK  in  1  set busy on MARK_DR (a result for that register has been issued).
- MARK_DR  in  ADDR_W  register to mark busy.
- CLR_REQ  in  1  start a clear sweep.
- DATA_A  out  DATA_W  read data, port A (combinational).
- DATA_B  out  DATA_W  read data, port B (combinational).
- RDY_A  out  1  port A operand valid (not busy).
- RDY_B  out  1  port B operand valid (not busy).
- CLR_BUSY  out  1  sweep in progress.
- LD_ERR  out  1  registered one-cycle pulse: an LD or MARK was dropped.

Behaviour:
- RESET (async, any time, including mid-sweep):
  - all registers = 0, all busy bits = 0, FSM = RF_IDLE, sweep index = 0.
  - CLR_BUSY = 0, LD_ERR = 0; DATA_A/DATA_B read 0.
- FSM states: RF_IDLE, RF_SWEEP.
  - RF_IDLE -> RF_SWEEP on CLR_REQ=1 at a rising edge; index <= 0.
  - RF_SWEEP: each edge, reg[index] <= 0, busy[index] <= 0, index++.
  - On the edge that clears index DEPTH-1, return to RF_IDLE.
  - Sweep length is exactly DEPTH cycles. CLR_BUSY = (state == RF_SWEEP), registered.
  - CLR_REQ while in RF_SWEEP is ignored; no restart or extension.
- Write, RF_IDLE only: LD=1 at an edge -> reg[DR] <= D_in and busy[DR] <= 0.
  - If ZERO_REG=1 and DR=0, the write is discarded silently (no LD_ERR).
- MARK, RF_IDLE only: busy[MARK_DR] <= 1.
  - If ZERO_REG=1 and MARK_DR=0, ignored.
  - MARK and LD to the same register in the same cycle: data is written, and busy ends at 1 (MARK wins).
- During RF_SWEEP: LD and MARK are dropped, and LD_ERR = 1 on the next cycle.
  - LD_ERR = 0 otherwise; back-to-back drops give a continuous high.
- Reads, combinational, 0-cycle latency: DATA_A = reg[SA]; DATA_B = reg[SB].
  - ZERO_REG=1 and SA/SB=0 -> 0.
  - BYPASS=1 and an accepted write this cycle with DR==SA -> DATA_A = D_in (same for B).
  - BYPASS=0 -> the old value is read until the edge.
- RDY_A = !busy[SA]; RDY_B = !busy[SB].
  - BYPASS=1: an accepted write with DR==SA forces RDY_A=1, unless a same-cycle MARK targets SA (same for B).
  - Forced 0 while CLR_BUSY=1.
  - Always 1 for register 0 when ZERO_REG=1.
- During a sweep, reads return current contents: swept registers read 0, not-yet-swept registers read old values.
- All index arithmetic is ADDR_W bits unsigned; the index does not wrap, because the FSM exits at DEPTH-1.

Decomposition:
- regfile_pkg holds:
  - sweep state enum {RF_IDLE, RF_SWEEP};
  - default constants RF_DATA_W=8, RF_ADDR_W=3;
  - a helper function for the one-hot decode of an ADDR_W address.
- One sub-module, rf_scoreboard: DEPTH busy bits with set (MARK), clear (write), clear-by-index (sweep), async RESET, and two read ports.
- Storage, bypass and the FSM stay in the top module.

Test Plan:
- Write/read: RESET, then LD=1 DR=5 D_in=0xA5; next cycle SA=5 SB=0 -> DATA_A=0xA5, DATA_B=0x00, RDY_A=RDY_B=1.
- Bypass: BYPASS=1, LD=1 DR=3 D_in=0x3C, SA=3 in the same cycle -> DATA_A=0x3C before the edge.
  - With BYPASS=0, the same stimulus gives the old value 0x00.
- Scoreboard: MARK MARK_DR=2 -> next cycle RDY_A=0 with SA=2.
  - LD DR=2 D_in=0x11 -> RDY_A=1 in that cycle (bypass) and after the edge.
  - MARK+LD to reg 2 in the same cycle -> RDY_A=0 afterwards, DATA_A=0x11.
- Sweep: fill regs 0..7 with 0x10..0x17, then pulse CLR_REQ -> CLR_BUSY high for exactly 8 cycles.
  - Reg k reads 0 from sweep cycle k+1 onward.
  - LD during the sweep -> LD_ERR pulses and the data is not stored.
- ZERO_REG=1: LD DR=0 D_in=0xFF -> DATA_A(SA=0)=0 and LD_ERR=0; MARK_DR=0 -> RDY_A stays 1.
- Reset mid-sweep: assert RESET at sweep cycle 3, asynchronously -> CLR_BUSY=0 immediately, all regs 0.
  - After release, a new CLR_REQ runs the full 8 cycles.
